// File: rtl/prio_pkg.sv
// Shared definitions for the registered priority encoder / round-robin arbiter.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   MODE_FIXED / MODE_RR  encoding of the mode input
//   clog2()               index width helper used to derive W from N
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Smallest r with 2**r >= n; callers guarantee n >= 2 so r >= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational wrapped priority encoder: first set bit searching downward from start.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
//
// Ports:
//   req    in  N  request vector
//   start  in  W  first index examined; search goes start, start-1, ..., 0, N-1, ..., start+1
//   found  out 1  at least one request bit is set
//   idx    out W  granted index, 0 when nothing is found
module prio_enc_core
  import prio_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  // One extra bit so (a + start + 1) never overflows before the mod-N fold;
  // both operands are < N <= 2**W, so the sum is < 2**(W+1).
  localparam logic [W:0] N_EXT = (W+1)'(N);

  logic [N-1:0] rot;
  logic [W:0]   src;
  logic [W-1:0] enc;
  logic [W:0]   sum;

  // rot[j] = req[(j + start + 1) mod N], so rot[N-1] is req[start] and a plain
  // MSB-first scan of rot walks req in the wrapped descending order.
  always_comb begin
    rot = '0;
    src = '0;
    for (int j = 0; j < N; j++) begin
      src = (W+1)'(j) + {1'b0, start} + (W+1)'(1);
      if (src >= N_EXT) begin
        src = src - N_EXT;
      end
      rot[j] = req[src[W-1:0]];
    end
  end

  // Fixed MSB-first encode of the rotated vector (later iterations override).
  always_comb begin
    enc = '0;
    for (int j = 0; j < N; j++) begin
      if (rot[j]) begin
        enc = W'(j);
      end
    end
  end

  // Undo the rotation: original index = (enc + start + 1) mod N.
  always_comb begin
    found = |req;
    sum   = {1'b0, enc} + {1'b0, start} + (W+1)'(1);
    if (sum >= N_EXT) begin
      sum = sum - N_EXT;
    end
    idx = found ? sum[W-1:0] : '0;
  end

endmodule

// File: rtl/prio_enc_rr_reg.sv
// Registered N-to-log2(N) priority encoder/arbiter, fixed (highest index) or round-robin.
// Latency: 1 cycle from req to out_idx/out_valid.
// Backpressure: while out_valid && !out_ready the outputs and pointer hold and req is ignored.
//
// Ports:
//   clk        in  1  clock, rising edge
//   rst_n      in  1  asynchronous active-low reset
//   mode       in  1  MODE_FIXED (highest index wins) or MODE_RR (round-robin)
//   req        in  N  request vector, sampled on every load cycle
//   out_ready  in  1  consumer takes out_idx when out_valid && out_ready
//   out_valid  out 1  out_idx holds a granted index
//   out_idx    out W  granted index, 0 whenever out_valid is 0
module prio_enc_rr_reg
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx
);

  localparam logic [W-1:0] IDX_MAX = W'(N-1);

  logic [W-1:0] ptr;
  logic [W-1:0] ptr_acc;
  logic [W-1:0] rr_start;
  logic [W-1:0] start;
  logic         accept;
  logic         load;
  logic         found;
  logic [W-1:0] enc_idx;

  assign accept = out_valid && out_ready;
  assign load   = !out_valid || out_ready;

  // Pointer value implied by the index being accepted right now. Feeding it
  // straight into the search start lets back-to-back grants rotate without
  // waiting a cycle for ptr to catch up.
  assign ptr_acc  = (out_idx == '0) ? IDX_MAX : out_idx - W'(1);
  assign rr_start = accept ? ptr_acc : ptr;
  assign start    = (mode == MODE_RR) ? rr_start : IDX_MAX;

  prio_enc_core #(
    .N (N),
    .W (W)
  ) u_core (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (enc_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      ptr       <= IDX_MAX;
    end else begin
      // ptr only advances in round-robin mode; a mode flip leaves it intact.
      if (accept && (mode == MODE_RR)) begin
        ptr <= ptr_acc;
      end
      if (load) begin
        out_valid <= found;
        out_idx   <= enc_idx;
      end
    end
  end

endmodule
